// File: rtl/io_mmio_pkg.sv
// Shared constants and types for the CPU-facing GPIO register window.
package io_mmio_pkg;

    localparam logic [2:0] OFF_SWITCH    = 3'd0;
    localparam logic [2:0] OFF_BTN_LEVEL = 3'd1;
    localparam logic [2:0] OFF_BTN_PEND  = 3'd2;
    localparam logic [2:0] OFF_BTN_CNT   = 3'd3;
    localparam logic [2:0] OFF_LED       = 3'd4;
    localparam logic [2:0] OFF_SEG       = 3'd5;
    localparam logic [2:0] OFF_TIMER     = 3'd6;

    localparam int NUM_BTN = 5;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

    localparam logic [15:0] BTN_CNT_MAX = 16'hFFFF;

    // Zero-extend a 16-bit field to a bus word.
    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/io_mmio_responder_btn_event_latch.sv
// Button event latch: level register, rising-edge detect, W1C pending bits
// (a new edge beats a clear) and a saturating press counter (a clear beats an edge).
module btn_event_latch
    import io_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        aresetn,
    input  btn_vec_t    btn_dbnc,
    input  btn_vec_t    pend_clr,
    input  logic        cnt_clr,
    output btn_vec_t    btn_level,
    output btn_vec_t    pending,
    output logic [15:0] btn_cnt
);

    btn_vec_t    level_r;
    btn_vec_t    prev_r;
    btn_vec_t    pend_r;
    btn_vec_t    edge_s;
    btn_vec_t    pend_next_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;

    // Edge detection and next-state for pending bits and the press counter.
    always_comb begin
        edge_s      = level_r & ~prev_r;
        pend_next_s = (pend_r & ~pend_clr) | edge_s;
        cnt_next_s  = cnt_r;
        if (cnt_clr) begin
            cnt_next_s = 16'h0000;
        end else if ((|edge_s) && (cnt_r != BTN_CNT_MAX)) begin
            cnt_next_s = cnt_r + 16'h0001;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Level register, edge history, pending bits and counter.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            level_r <= '0;
            prev_r  <= '0;
            pend_r  <= '0;
            cnt_r   <= 16'h0000;
        end else begin
            level_r <= btn_dbnc;
            prev_r  <= level_r;
            pend_r  <= pend_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign btn_level = level_r;
    assign pending   = pend_r;
    assign btn_cnt   = cnt_r;

endmodule

// File: rtl/io_mmio_responder.sv
// CPU load/store responder for switches, buttons, LEDs and the segment value.
// Optional free-running timer at offset 6 when IO_MMIO_TIMER_EN is defined.
module io_mmio_responder
    import io_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
)
(
    input  logic        clk,
    input  logic        aresetn,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic [15:0] switch,
    input  btn_vec_t    btn_dbnc,
    output logic [15:0] led_out,
    output logic [31:0] seg_value,
    output logic        btn_irq
);

    logic        hit_s;
    logic [2:0]  off_s;
    logic        wr_s;
    logic        rd_s;
    logic [15:0] sw_meta_r;
    logic [15:0] sw_sync_r;
    logic [15:0] led_r;
    logic [31:0] seg_r;
    logic [31:0] rdata_r;
    logic        rvalid_r;
    logic [31:0] rd_mux_s;
    logic [31:0] timer_s;
    btn_vec_t    pend_clr_s;
    logic        cnt_clr_s;
    btn_vec_t    btn_level_s;
    btn_vec_t    pending_s;
    logic [15:0] btn_cnt_s;
    logic        unused_addr_s;

    assign hit_s         = (addr[31:5] == BASE_ADDR[31:5]);
    assign off_s         = addr[4:2];
    assign wr_s          = we & hit_s;
    assign rd_s          = re & hit_s;
    assign unused_addr_s = ^addr[1:0];

    // A load of PEND clears exactly the bits it returns; a store clears by mask.
    always_comb begin
        pend_clr_s = '0;
        cnt_clr_s  = 1'b0;
        if (hit_s && (off_s == OFF_BTN_PEND)) begin
            if (we) begin
                pend_clr_s = pend_clr_s | wdata[NUM_BTN-1:0];
            end else begin
                pend_clr_s = pend_clr_s;
            end
            if (re) begin
                pend_clr_s = pend_clr_s | pending_s;
            end else begin
                pend_clr_s = pend_clr_s;
            end
        end else begin
            pend_clr_s = '0;
        end
        if (wr_s && (off_s == OFF_BTN_CNT)) begin
            cnt_clr_s = 1'b1;
        end else begin
            cnt_clr_s = 1'b0;
        end
    end

    btn_event_latch u_btn_event_latch (
        .clk       (clk),
        .aresetn   (aresetn),
        .btn_dbnc  (btn_dbnc),
        .pend_clr  (pend_clr_s),
        .cnt_clr   (cnt_clr_s),
        .btn_level (btn_level_s),
        .pending   (pending_s),
        .btn_cnt   (btn_cnt_s)
    );

`ifdef IO_MMIO_TIMER_EN
    logic [31:0] timer_r;

    // Free-running cycle counter; a store reloads it and counting resumes next cycle.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            timer_r <= 32'h0000_0000;
        end else if (wr_s && (off_s == OFF_TIMER)) begin
            timer_r <= wdata;
        end else begin
            timer_r <= timer_r + 32'h0000_0001;
        end
    end

    assign timer_s = timer_r;
`else
    assign timer_s = 32'h0000_0000;
`endif

    // Two-flop synchronizer for the asynchronous switch levels.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            sw_meta_r <= 16'h0000;
            sw_sync_r <= 16'h0000;
        end else begin
            sw_meta_r <= switch;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Readback mux over the pre-store register values.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (off_s)
            OFF_SWITCH:    rd_mux_s = zext16(sw_sync_r);
            OFF_BTN_LEVEL: rd_mux_s = {{(32-NUM_BTN){1'b0}}, btn_level_s};
            OFF_BTN_PEND:  rd_mux_s = {{(32-NUM_BTN){1'b0}}, pending_s};
            OFF_BTN_CNT:   rd_mux_s = zext16(btn_cnt_s);
            OFF_LED:       rd_mux_s = zext16(led_r);
            OFF_SEG:       rd_mux_s = seg_r;
            OFF_TIMER:     rd_mux_s = timer_s;
            default:       rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Writable output registers and the registered load response.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            led_r    <= 16'h0000;
            seg_r    <= 32'h0000_0000;
            rdata_r  <= 32'h0000_0000;
            rvalid_r <= 1'b0;
        end else begin
            if (wr_s && (off_s == OFF_LED)) begin
                led_r <= wdata[15:0];
            end else begin
                led_r <= led_r;
            end
            if (wr_s && (off_s == OFF_SEG)) begin
                seg_r <= wdata;
            end else begin
                seg_r <= seg_r;
            end
            if (rd_s) begin
                rdata_r <= rd_mux_s;
            end else begin
                rdata_r <= rdata_r;
            end
            rvalid_r <= rd_s;
        end
    end

    assign rdata     = rdata_r;
    assign rvalid    = rvalid_r;
    assign led_out   = led_r;
    assign seg_value = seg_r;
    assign btn_irq   = |pending_s;

endmodule
